// File: rtl/mrd_rdx5_unload.sv
// Radix-5 result unloader: buffers parallel 5-bin vectors in a circular buffer
// and streams them out one bin per transfer over a valid/ready handshake.
module mrd_rdx5_unload #(
    parameter int wDataInOut = 30,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_val,
    input  logic signed [wDataInOut-1:0] din_real [0:4],
    input  logic signed [wDataInOut-1:0] din_imag [0:4],
    input  logic                         out_rdy,
    output logic                         out_val,
    output logic signed [wDataInOut-1:0] dout_real,
    output logic signed [wDataInOut-1:0] dout_imag,
    output logic [2:0]                   out_idx,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic                         in_space,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic signed [wDataInOut-1:0] mem_real_q [0:DEPTH-1][0:4];
    logic signed [wDataInOut-1:0] mem_imag_q [0:DEPTH-1][0:4];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [2:0]    idx_q, idx_d;
    logic          overflow_q, overflow_d;

    logic xfer_s, pop_s, full_s, wr_s, drop_s;
    logic signed [wDataInOut-1:0] head_real_s, head_imag_s;

    // Handshake decode and next-state for pointers, level, bin counter and overflow
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;

        xfer_s = (level_q != {LW{1'b0}}) && out_rdy;
        pop_s  = xfer_s && (idx_q == 3'd4);
        full_s = (level_q == LW'(DEPTH));
        // A pop at full frees a slot in the same cycle, so the write is still taken
        wr_s   = in_val && (!full_s || pop_s);
        drop_s = in_val && full_s && !pop_s;

        if (xfer_s) begin
            if (pop_s) begin
                idx_d    = 3'd0;
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                idx_d    = idx_q + 3'd1;
                rd_ptr_d = rd_ptr_q;
            end
        end else begin
            idx_d    = idx_q;
            rd_ptr_d = rd_ptr_q;
        end

        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({wr_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        overflow_d = overflow_q | drop_s;
    end

    // Control state register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            level_q    <= {LW{1'b0}};
            idx_q      <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Vector storage; contents are meaningless while empty, so no reset
    always_ff @(posedge clk) begin
        if (wr_s) begin
            for (int b = 0; b < 5; b++) begin
                mem_real_q[wr_ptr_q][b] <= din_real[b];
                mem_imag_q[wr_ptr_q][b] <= din_imag[b];
            end
        end
    end

    // Select the current bin of the head vector
    always_comb begin
        head_real_s = mem_real_q[rd_ptr_q][0];
        head_imag_s = mem_imag_q[rd_ptr_q][0];
        case (idx_q)
            3'd0: begin
                head_real_s = mem_real_q[rd_ptr_q][0];
                head_imag_s = mem_imag_q[rd_ptr_q][0];
            end
            3'd1: begin
                head_real_s = mem_real_q[rd_ptr_q][1];
                head_imag_s = mem_imag_q[rd_ptr_q][1];
            end
            3'd2: begin
                head_real_s = mem_real_q[rd_ptr_q][2];
                head_imag_s = mem_imag_q[rd_ptr_q][2];
            end
            3'd3: begin
                head_real_s = mem_real_q[rd_ptr_q][3];
                head_imag_s = mem_imag_q[rd_ptr_q][3];
            end
            3'd4: begin
                head_real_s = mem_real_q[rd_ptr_q][4];
                head_imag_s = mem_imag_q[rd_ptr_q][4];
            end
            default: begin
                head_real_s = mem_real_q[rd_ptr_q][0];
                head_imag_s = mem_imag_q[rd_ptr_q][0];
            end
        endcase
    end

    assign out_val   = (level_q != {LW{1'b0}});
    assign dout_real = head_real_s;
    assign dout_imag = head_imag_s;
    assign out_idx   = idx_q;
    assign out_sop   = (idx_q == 3'd0) && out_val;
    assign out_eop   = (idx_q == 3'd4) && out_val;
    assign in_space  = (level_q < LW'(DEPTH));
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mrd_rdx5_unload.sv
// Scoreboard bench for mrd_rdx5_unload: directed vectors push expected samples,
// a negedge monitor compares every presented sample against the queue head.
module tb_mrd_rdx5_unload;

    localparam int W     = 30;
    localparam int DEPTH = 4;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] i;
        logic [2:0]   idx;
    } samp_t;

    logic                clk;
    logic                rst_n;
    logic                in_val;
    logic signed [W-1:0] din_real [0:4];
    logic signed [W-1:0] din_imag [0:4];
    logic                out_rdy;
    logic                out_val;
    logic signed [W-1:0] dout_real;
    logic signed [W-1:0] dout_imag;
    logic [2:0]          out_idx;
    logic                out_sop;
    logic                out_eop;
    logic                in_space;
    logic [2:0]          level;
    logic                overflow;

    samp_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    lvl_max = 0;
    int    xfers = 0;

    mrd_rdx5_unload #(.wDataInOut(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_val(in_val),
        .din_real(din_real), .din_imag(din_imag), .out_rdy(out_rdy),
        .out_val(out_val), .dout_real(dout_real), .dout_imag(dout_imag),
        .out_idx(out_idx), .out_sop(out_sop), .out_eop(out_eop),
        .in_space(in_space), .level(level), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] vr(input int k, input int b);
        int t[5];
        t = '{10, -20, 30, -40, 50};
        if (k == 0) return W'(t[b]);
        return W'(k * 1000 - b * 37 - 1234567);
    endfunction

    function automatic logic [W-1:0] vi(input int k, input int b);
        if (k == 0) return W'(b + 1);
        return W'(-(k * 77) + b * 5000);
    endfunction

    // Drive vector k for the current cycle; push its samples only when it will be kept
    task automatic send(input int k, input bit acc);
        samp_t s;
        in_val = 1'b1;
        for (int b = 0; b < 5; b++) begin
            din_real[b] = vr(k, b);
            din_imag[b] = vi(k, b);
            if (acc) begin
                s.r = vr(k, b); s.i = vi(k, b); s.idx = 3'(b);
                sb.push_back(s);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input logic [2:0] n);
        for (int c = 0; c < 60; c++) begin
            tick();
            if (out_val && out_idx == n) return;
        end
        chk("wait_idx_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_empty();
        for (int c = 0; c < 300; c++) begin
            tick();
            if (level == 3'd0) return;
        end
        chk("wait_empty_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2;
        chk("rst_out_val", {31'd0, out_val}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_in_space", {31'd0, in_space}, 32'd1);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(level) > lvl_max) lvl_max = int'(level);
            if (out_val) begin
                if (sb.size() == 0) begin
                    chk("unexpected_sample", 32'd1, 32'd0);
                end else begin
                    chk("dout_real", {2'd0, dout_real}, {2'd0, sb[0].r});
                    chk("dout_imag", {2'd0, dout_imag}, {2'd0, sb[0].i});
                    chk("out_idx", {29'd0, out_idx}, {29'd0, sb[0].idx});
                    chk("out_sop", {31'd0, out_sop}, {31'd0, sb[0].idx == 3'd0});
                    chk("out_eop", {31'd0, out_eop}, {31'd0, sb[0].idx == 3'd4});
                    if (out_rdy) begin
                        void'(sb.pop_front());
                        xfers++;
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
        for (int b = 0; b < 5; b++) begin
            din_real[b] = '0;
            din_imag[b] = '0;
        end
        #12;
        chk("init_out_val", {31'd0, out_val}, 32'd0);
        chk("init_level", {29'd0, level}, 32'd0);
        chk("init_in_space", {31'd0, in_space}, 32'd1);
        chk("init_sop_eop", {30'd0, out_sop, out_eop}, 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Single vector, free-flowing output
        out_rdy = 1'b1;
        send(0, 1'b1);
        tick();
        in_val = 1'b0;
        chk("lat_out_val", {31'd0, out_val}, 32'd1);
        chk("lat_sop", {31'd0, out_sop}, 32'd1);
        wait_idx(3'd4);
        tick();
        chk("single_level_back", {29'd0, level}, 32'd0);
        chk("single_sb_empty", sb.size(), 32'd0);

        // Backpressure at bin 2
        send(1, 1'b1);
        tick();
        in_val = 1'b0;
        wait_idx(3'd2);
        out_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_idx_hold", {29'd0, out_idx}, 32'd2);
            chk("bp_real_hold", {2'd0, dout_real}, {2'd0, vr(1, 2)});
        end
        out_rdy = 1'b1;
        wait_empty();
        chk("bp_sb_empty", sb.size(), 32'd0);

        // Fill past capacity
        do_reset();
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(10 + k, k < DEPTH);
            tick();
        end
        in_val = 1'b0;
        chk("fill_level", {29'd0, level}, 32'd4);
        chk("fill_in_space", {31'd0, in_space}, 32'd0);
        chk("fill_overflow", {31'd0, overflow}, 32'd1);
        out_rdy = 1'b1;
        wait_empty();
        chk("fill_sb_empty", sb.size(), 32'd0);
        chk("fill_overflow_sticky", {31'd0, overflow}, 32'd1);

        // Write coinciding with pop while full
        do_reset();
        out_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(20 + k, 1'b1);
            tick();
        end
        in_val = 1'b0;
        out_rdy = 1'b1;
        wait_idx(3'd4);
        chk("sim_pre_level", {29'd0, level}, 32'd4);
        send(24, 1'b1);
        tick();
        in_val = 1'b0;
        chk("sim_level", {29'd0, level}, 32'd4);
        chk("sim_overflow", {31'd0, overflow}, 32'd0);
        wait_empty();
        chk("sim_sb_empty", sb.size(), 32'd0);

        // Ten vectors at one per five cycles, wrapping pointers
        do_reset();
        out_rdy = 1'b1;
        lvl_max = 0;
        xfers = 0;
        for (int k = 0; k < 10; k++) begin
            send(30 + k, 1'b1);
            tick();
            in_val = 1'b0;
            repeat (4) tick();
        end
        wait_empty();
        chk("wrap_xfers", xfers, 32'd50);
        chk("wrap_level_le2", {31'd0, lvl_max <= 2}, 32'd1);
        chk("wrap_sb_empty", sb.size(), 32'd0);

        // Reset while bin 3 is on the output
        send(40, 1'b1);
        tick();
        in_val = 1'b0;
        wait_idx(3'd3);
        rst_n = 1'b0;
        #1;
        chk("rmid_out_val", {31'd0, out_val}, 32'd0);
        chk("rmid_level", {29'd0, level}, 32'd0);
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) tick();
        chk("rmid_quiet", {31'd0, out_val}, 32'd0);
        send(41, 1'b1);
        tick();
        in_val = 1'b0;
        chk("rmid_restart_idx", {29'd0, out_idx}, 32'd0);
        wait_empty();
        chk("rmid_sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
